// File: rtl/text_disp_pkg.sv
// Shared constants, FSM state type and glyph lookup for the text_grid_display overlay.
// Glyph tables cover a small demo character set; other printable codes render as a box.
package text_disp_pkg;

    localparam logic [23:0] CODE_NL    = 24'h00000A;
    localparam logic [23:0] CODE_CR    = 24'h00000D;
    localparam logic [23:0] CODE_BS    = 24'h000008;
    localparam logic [23:0] CODE_SPACE = 24'h000020;
    localparam logic [3:0]  THAI_PREFIX = 4'b1110;

    localparam int unsigned CELL_W   = 8;
    localparam int unsigned CELL_H   = 16;
    localparam int unsigned PIPE_LAT = 3;

    typedef enum logic {CLEAR, IDLE} state_t;

    // Glyphs are 16 rows of 8 bits, top row in the most significant byte, MSB = leftmost pixel.
    localparam logic [127:0] GLYPH_A      = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_H      = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_I_LC   = 128'h0000_1818_0038_1818_1818_183C_0000_0000;
    localparam logic [127:0] GLYPH_BOX    = 128'h0000_7E42_4242_4242_4242_427E_0000_0000;
    localparam logic [127:0] GLYPH_KO_KAI = 128'h0000_0000_7CC6_0606_6666_6666_0000_0000;

    function automatic logic [7:0] glyph_row(input logic [127:0] g, input logic [3:0] row);
        return g[{~row, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] ascii_glyph(input logic [23:0] code, input logic [3:0] row);
        logic [127:0] g;
        g = '0;
        if (code[23:8] == 16'h0000) begin
            if (code[7:0] == 8'h41) begin
                g = GLYPH_A;
            end else if (code[7:0] == 8'h48) begin
                g = GLYPH_H;
            end else if (code[7:0] == 8'h69) begin
                g = GLYPH_I_LC;
            end else if (code[7:0] > 8'h20 && code[7:0] < 8'h7F) begin
                g = GLYPH_BOX;
            end
        end
        return glyph_row(g, row);
    endfunction

    function automatic logic [7:0] thai_glyph(input logic [23:0] code, input logic [3:0] row);
        logic [127:0] g;
        g = (code == 24'hE0B881) ? GLYPH_KO_KAI : GLYPH_BOX;
        return glyph_row(g, row);
    endfunction

endpackage

// File: rtl/text_char_buffer.sv
// Simple dual-port character buffer: one synchronous write port, one registered read port.
// A same-cycle write and read of one address returns the old contents.
module text_char_buffer #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 64
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_grid_display.sv
// Text-mode overlay: cursor-driven write port into a COLS x ROWS character grid, 3-stage pixel path.
// Define CURSOR_BLINK_EN to draw a blinking underline cursor (toggles every 32 frames).
module text_grid_display
    import text_disp_pkg::*;
#(
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned X0      = 256,
    parameter int unsigned Y0      = 192,
    parameter logic [11:0] FG_EVEN = 12'h00F,
    parameter logic [11:0] FG_ODD  = 12'h00E,
    parameter logic [11:0] BG      = 12'hFFF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_video_on,
    input  logic [9:0]               i_x,
    input  logic [9:0]               i_y,
    input  logic [23:0]              i_wr_data,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic                     i_clr,
    output logic [$clog2(COLS)-1:0]  o_cursor_col,
    output logic [$clog2(ROWS)-1:0]  o_cursor_row,
    output logic [11:0]              o_rgb
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned AW = CW + RW;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
    localparam logic [10:0] X0_L = 11'(X0);
    localparam logic [10:0] XE_L = 11'(X0 + CELL_W * COLS);
    localparam logic [10:0] Y0_L = 11'(Y0);
    localparam logic [10:0] YE_L = 11'(Y0 + CELL_H * ROWS);

    state_t          r_state;
    logic [AW-1:0]   r_sweep;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [AW-1:0]   w_cursor;
    logic            w_accept;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [23:0]     w_wdata;

    assign w_cursor     = {r_row, r_col};
    assign o_wr_ready   = (r_state == IDLE) && !i_clr;
    assign w_accept     = i_wr_valid && o_wr_ready;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;

    // Cursor/clear FSM; clr has priority over everything except reset.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_state <= CLEAR;
            r_sweep <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else if (r_state == CLEAR) begin
            r_sweep <= r_sweep + 1'b1;
            if (r_sweep == LAST_ADDR) begin
                r_state <= IDLE;
            end
        end else if (i_wr_valid) begin
            case (i_wr_data)
                CODE_NL: begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end
                CODE_CR: r_col <= '0;
                CODE_BS: begin
                    if (w_cursor != '0) begin
                        {r_row, r_col} <= w_cursor - 1'b1;
                    end
                end
                default: {r_row, r_col} <= w_cursor + 1'b1;
            endcase
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_cursor;
        w_wdata = CODE_SPACE;
        if (!i_reset) begin
            if (r_state == CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_sweep;
            end else if (w_accept) begin
                if (i_wr_data == CODE_BS) begin
                    w_we    = (w_cursor != '0);
                    w_waddr = w_cursor - 1'b1;
                end else if (i_wr_data != CODE_NL && i_wr_data != CODE_CR) begin
                    w_we    = 1'b1;
                    w_wdata = i_wr_data;
                end
            end
        end
    end

    // S0: window test and cell decode from the raw counters.
    logic          w_in_win;
    logic [CW+2:0] w_dx;
    logic [RW+3:0] w_dy;
    logic [AW-1:0] w_raddr;
    logic          w_ul;
    logic [23:0]   w_code;

    assign w_in_win = ({1'b0, i_x} >= X0_L) && ({1'b0, i_x} < XE_L) &&
                      ({1'b0, i_y} >= Y0_L) && ({1'b0, i_y} < YE_L);
    assign w_dx     = (CW + 3)'(i_x - X0_L[9:0]);
    assign w_dy     = (RW + 4)'(i_y - Y0_L[9:0]);
    assign w_raddr  = {w_dy[RW+3:4], w_dx[CW+2:3]};

`ifdef CURSOR_BLINK_EN
    logic       w_origin;
    logic       r_origin;
    logic [4:0] r_frame_cnt;
    logic       r_blink;

    assign w_origin = (i_x == 10'd0) && (i_y == 10'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_origin    <= 1'b0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_origin <= w_origin;
            if (w_origin && !r_origin) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (r_frame_cnt == 5'd31) begin
                    r_blink <= !r_blink;
                end
            end
        end
    end

    // Underline occupies the bottom two pixel rows of the cursor cell.
    assign w_ul = r_blink && (w_raddr == w_cursor) && (w_dy[3:1] == 3'b111);
`else
    assign w_ul = 1'b0;
`endif

    text_char_buffer #(
        .AW    (AW),
        .DW    (24),
        .DEPTH (CELLS)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_code)
    );

    logic       r_s1_in_win, r_s1_video_on, r_s1_odd, r_s1_ul;
    logic [2:0] r_s1_bit_col;
    logic [3:0] r_s1_char_row;
    logic       r_s2_in_win, r_s2_video_on, r_s2_odd, r_s2_ul, r_s2_is_thai;
    logic [2:0] r_s2_bit_col;
    logic [7:0] r_ascii_rom_q, r_thai_rom_q;
    logic [7:0] w_glyph_row;
    logic       w_bit;
    logic [11:0] r_rgb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_in_win   <= 1'b0;
            r_s1_video_on <= 1'b0;
            r_s1_odd      <= 1'b0;
            r_s1_ul       <= 1'b0;
            r_s1_bit_col  <= '0;
            r_s1_char_row <= '0;
            r_s2_in_win   <= 1'b0;
            r_s2_video_on <= 1'b0;
            r_s2_odd      <= 1'b0;
            r_s2_ul       <= 1'b0;
            r_s2_is_thai  <= 1'b0;
            r_s2_bit_col  <= '0;
            r_ascii_rom_q <= '0;
            r_thai_rom_q  <= '0;
            r_rgb         <= BG;
        end else begin
            r_s1_in_win   <= w_in_win;
            r_s1_video_on <= i_video_on;
            r_s1_odd      <= w_dx[3];
            r_s1_ul       <= w_ul;
            r_s1_bit_col  <= w_dx[2:0];
            r_s1_char_row <= w_dy[3:0];

            r_s2_in_win   <= r_s1_in_win;
            r_s2_video_on <= r_s1_video_on;
            r_s2_odd      <= r_s1_odd;
            r_s2_ul       <= r_s1_ul;
            r_s2_bit_col  <= r_s1_bit_col;
            r_s2_is_thai  <= (w_code[23:20] == THAI_PREFIX);
            r_ascii_rom_q <= ascii_glyph(w_code, r_s1_char_row);
            r_thai_rom_q  <= thai_glyph(w_code, r_s1_char_row);

            if (!r_s2_video_on) begin
                r_rgb <= 12'h000;
            end else if (r_s2_in_win && (w_bit || r_s2_ul)) begin
                r_rgb <= r_s2_odd ? FG_ODD : FG_EVEN;
            end else begin
                r_rgb <= BG;
            end
        end
    end

    assign w_glyph_row = r_s2_is_thai ? r_thai_rom_q : r_ascii_rom_q;
    assign w_bit       = w_glyph_row[~r_s2_bit_col];
    assign o_rgb       = r_rgb;

endmodule

// File: tb/tb_text_grid_display.sv
// Self-checking bench for text_grid_display (default build, cursor blink disabled).
module tb_text_grid_display;

    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int X0   = 256;
    localparam int Y0   = 192;
    localparam logic [11:0] FG_E = 12'h00F;
    localparam logic [11:0] FG_O = 12'h00E;
    localparam logic [11:0] BGC  = 12'hFFF;

    localparam logic [127:0] G_A   = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] G_H   = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
    localparam logic [127:0] G_I   = 128'h0000_1818_0038_1818_1818_183C_0000_0000;
    localparam logic [127:0] G_BOX = 128'h0000_7E42_4242_4242_4242_427E_0000_0000;
    localparam logic [127:0] G_KO  = 128'h0000_0000_7CC6_0606_6666_6666_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [23:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        clr = 1'b0;
    logic [3:0]  ccol;
    logic [1:0]  crow;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    text_grid_display #(
        .COLS    (16),
        .ROWS    (4),
        .X0      (256),
        .Y0      (192),
        .FG_EVEN (12'h00F),
        .FG_ODD  (12'h00E),
        .BG      (12'hFFF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_video_on   (video_on),
        .i_x          (x),
        .i_y          (y),
        .i_wr_data    (wr_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_clr        (clr),
        .o_cursor_col (ccol),
        .o_cursor_row (crow),
        .o_rgb        (rgb)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] grid [COLS*ROWS];
    int m_col, m_row;

    typedef struct { logic chk; logic [11:0] exp; int px; int py; } pix_t;
    pix_t sb[$];

    typedef struct { logic [23:0] code; int ecol; int erow; } wvec_t;
    wvec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_glyph(input logic [23:0] code, input int r);
        logic [127:0] g;
        g = '0;
        if (code[23:20] == 4'hE) begin
            g = (code == 24'hE0B881) ? G_KO : G_BOX;
        end else if (code[23:8] == 16'h0) begin
            case (code[7:0])
                8'h41:   g = G_A;
                8'h48:   g = G_H;
                8'h69:   g = G_I;
                default: if (code[7:0] >= 8'h21 && code[7:0] <= 8'h7E) g = G_BOX;
            endcase
        end
        return g[127 - 8*r -: 8];
    endfunction

    function automatic logic [11:0] exp_pix(input int px, input int py, input logic von);
        int dx, dy, col, row;
        logic [7:0] bits;
        if (!von) return 12'h000;
        if (px < X0 || px >= X0 + 8*COLS || py < Y0 || py >= Y0 + 16*ROWS) return BGC;
        dx = px - X0;
        dy = py - Y0;
        col = dx / 8;
        row = dy / 16;
        bits = tb_glyph(grid[row*COLS + col], dy % 16);
        if (bits[7 - dx % 8]) return (col % 2 == 1) ? FG_O : FG_E;
        return BGC;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COLS*ROWS; i++) grid[i] = 24'h000020;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_write(input logic [23:0] c);
        if (c == 24'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (c == 24'h0D) begin
            m_col = 0;
        end else if (c == 24'h08) begin
            if (m_col != 0 || m_row != 0) begin
                if (m_col == 0) begin
                    m_col = COLS - 1;
                    m_row = m_row - 1;
                end else begin
                    m_col = m_col - 1;
                end
                grid[m_row*COLS + m_col] = 24'h000020;
            end
        end else begin
            grid[m_row*COLS + m_col] = c;
            m_col = m_col + 1;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end
    endtask

    task automatic do_write(input logic [23:0] c);
        @(negedge clk);
        wr_data  = c;
        wr_valid = 1'b1;
        #1 check("wr_ready_idle", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        model_write(c);
    endtask

    task automatic pix(input int px, input int py, input logic von, input logic chk);
        pix_t e;
        @(negedge clk);
        if (sb.size() >= 3) begin
            e = sb.pop_front();
            if (e.chk) check($sformatf("rgb(%0d,%0d)", e.px, e.py), 32'(rgb), 32'(e.exp));
        end
        x        = 10'(px);
        y        = 10'(py);
        video_on = von;
        e.chk = chk;
        e.exp = exp_pix(px, py, von);
        e.px  = px;
        e.py  = py;
        sb.push_back(e);
    endtask

    task automatic scan(input int xl, input int xh, input int yl, input int yh, input logic von);
        for (int yy = yl; yy <= yh; yy++)
            for (int xx = xl; xx <= xh; xx++) pix(xx, yy, von, 1'b1);
        repeat (3) pix(0, 0, 1'b0, 1'b0);
        sb.delete();
    endtask

    task automatic wait_sweep(input string name);
        repeat (63) begin
            @(negedge clk);
            check({name, "_busy"}, 32'(wr_ready), 32'd0);
        end
        @(negedge clk);
        check({name, "_done"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] fill [4];
        fill[0] = 24'h41; fill[1] = 24'h48; fill[2] = 24'h69; fill[3] = 24'h5A;

        vecs[0]  = '{24'h000041, 1, 0};
        vecs[1]  = '{24'h000048, 2, 0};
        vecs[2]  = '{24'h000069, 3, 0};
        vecs[3]  = '{24'h000008, 2, 0};
        vecs[4]  = '{24'h00000D, 0, 0};
        vecs[5]  = '{24'h00000A, 0, 1};
        vecs[6]  = '{24'h000008, 15, 0};
        vecs[7]  = '{24'h00000A, 0, 1};
        vecs[8]  = '{24'hE0B881, 1, 1};
        vecs[9]  = '{24'h00005A, 2, 1};
        vecs[10] = '{24'h00000A, 0, 2};
        vecs[11] = '{24'h00000A, 0, 3};
        vecs[12] = '{24'h00000A, 0, 0};

        model_clear();
        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'(BGC));
        check("reset_ready", 32'(wr_ready), 32'd0);
        check("reset_col", 32'(ccol), 32'd0);
        check("reset_row", 32'(crow), 32'd0);
        reset = 1'b0;
        wait_sweep("init_sweep");
        check("init_col", 32'(ccol), 32'd0);
        check("init_row", 32'(crow), 32'd0);
        scan(X0 - 4, X0 + 8*COLS + 3, Y0 - 2, Y0 + 16*ROWS + 1, 1'b1);

        for (int i = 0; i < 13; i++) begin
            do_write(vecs[i].code);
            check($sformatf("vec%0d_col", i), 32'(ccol), 32'(vecs[i].ecol));
            check($sformatf("vec%0d_row", i), 32'(crow), 32'(vecs[i].erow));
        end
        scan(X0 - 4, X0 + 8*COLS + 3, Y0 - 2, Y0 + 16*ROWS + 1, 1'b1);
        scan(X0 - 6, X0 + 14, Y0 - 2, Y0 + 18, 1'b0);

        // Backspace at home: no move, no write.
        do_write(24'h000008);
        check("bs_home_col", 32'(ccol), 32'd0);
        check("bs_home_row", 32'(crow), 32'd0);
        scan(X0, X0 + 15, Y0, Y0 + 15, 1'b1);

        // clr together with a write: write dropped, then restart the sweep mid-way.
        @(negedge clk);
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 24'h000041;
        #1 check("clr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        wr_valid = 1'b0;
        check("clr_busy0", 32'(wr_ready), 32'd0);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("reclr_busy0", 32'(wr_ready), 32'd0);
        wait_sweep("reclr");
        model_clear();
        check("clr_col", 32'(ccol), 32'd0);
        check("clr_row", 32'(crow), 32'd0);
        scan(X0, X0 + 8*COLS - 1, Y0, Y0 + 16*ROWS - 1, 1'b1);

        for (int i = 0; i < COLS*ROWS; i++) begin
            do_write(fill[i % 4]);
            if (i == 16) begin
                check("w17_col", 32'(ccol), 32'd1);
                check("w17_row", 32'(crow), 32'd1);
            end
            if (i == 62) begin
                check("w63_col", 32'(ccol), 32'd15);
                check("w63_row", 32'(crow), 32'd3);
            end
            if (i == 63) begin
                check("w64_col", 32'(ccol), 32'd0);
                check("w64_row", 32'(crow), 32'd0);
            end
        end
        scan(X0 - 2, X0 + 8*COLS + 1, Y0 - 1, Y0 + 16*ROWS, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
